// File: rtl/instruction_decoder_pipe_pkg.sv
// Shared CU definitions: occupancy encoding, default widths, instruction indices.
package instruction_decoder_pipe_pkg;

    localparam int unsigned DEF_CODE_W    = 2;
    localparam int unsigned DEF_NUM_INSTR = 4;
    localparam int unsigned DEF_OPERAND_W = 8;
    localparam int unsigned DEF_CNT_W     = 8;

    // Instruction indices into the one-hot vector; 2 and 3 are reserved for future opcodes.
    localparam int unsigned INSTR_ADD   = 0;
    localparam int unsigned INSTR_JUMP  = 1;
    localparam int unsigned INSTR_RSVD2 = 2;
    localparam int unsigned INSTR_RSVD3 = 3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/instruction_decoder_pipe_onehot_decoder.sv
// Combinational CODE_W -> NUM_INSTR one-hot decode with an out-of-range flag.
module onehot_decoder #(
    parameter int unsigned CODE_W    = 2,
    parameter int unsigned NUM_INSTR = 4
) (
    input  logic [CODE_W-1:0]    code,
    output logic [NUM_INSTR-1:0] onehot_c,
    output logic                 illegal_c
);

    localparam int unsigned CMP_W = CODE_W + 1;

    // Reject parameter sets that cannot be decoded.
    if (NUM_INSTR < 1 || NUM_INSTR > (2 ** CODE_W)) begin : g_bad_params
        $error("onehot_decoder: NUM_INSTR must be in 1..2**CODE_W");
    end

    // One comparator per legal instruction.
    for (genvar i = 0; i < NUM_INSTR; i++) begin : g_bit
        assign onehot_c[i] = (code == CODE_W'(i));
    end

    // Extra bit so NUM_INSTR == 2**CODE_W is representable.
    assign illegal_c = ({1'b0, code} >= CMP_W'(NUM_INSTR));

endmodule

// File: rtl/instruction_decoder_pipe.sv
// Registered instruction decoder with valid/ready, 2-entry skid buffer, flush and illegal counting.
module instruction_decoder_pipe
    import instruction_decoder_pipe_pkg::*;
#(
    parameter int unsigned CODE_W    = DEF_CODE_W,
    parameter int unsigned NUM_INSTR = DEF_NUM_INSTR,
    parameter int unsigned OPERAND_W = DEF_OPERAND_W,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [CODE_W-1:0]    InstructionCode,
    input  logic [OPERAND_W-1:0] Operand,
    input  logic                 Flush,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [NUM_INSTR-1:0] Instruction,
    output logic [OPERAND_W-1:0] OutOperand,
    output logic                 Illegal,
    output logic [CNT_W-1:0]     IllegalCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_e                 state, state_n;
    logic                 in_ready_q, in_ready_n;
    logic                 out_valid_q, out_valid_n;
    logic [NUM_INSTR-1:0] out_instr_q, out_instr_n;
    logic [OPERAND_W-1:0] out_op_q, out_op_n;
    logic                 out_ill_q, out_ill_n;
    logic [NUM_INSTR-1:0] skid_instr_q, skid_instr_n;
    logic [OPERAND_W-1:0] skid_op_q, skid_op_n;
    logic                 skid_ill_q, skid_ill_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [NUM_INSTR-1:0] dec_instr_c;
    logic                 dec_ill_c;
    logic                 acc_c, pop_c;

    // Decode on the input side so both storage slots hold decoded entries.
    onehot_decoder #(
        .CODE_W    (CODE_W),
        .NUM_INSTR (NUM_INSTR)
    ) u_dec (
        .code      (InstructionCode),
        .onehot_c  (dec_instr_c),
        .illegal_c (dec_ill_c)
    );

    assign acc_c = InValid && in_ready_q;
    assign pop_c = out_valid_q && OutReady;

    // Occupancy, datapath and counter next-state; flush overrides everything except the counter hold.
    always_comb begin
        state_n      = state;
        out_instr_n  = out_instr_q;
        out_op_n     = out_op_q;
        out_ill_n    = out_ill_q;
        skid_instr_n = skid_instr_q;
        skid_op_n    = skid_op_q;
        skid_ill_n   = skid_ill_q;
        cnt_n        = cnt_q;

        if (Flush) begin
            state_n = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (acc_c) begin
                        out_instr_n = dec_instr_c;
                        out_op_n    = Operand;
                        out_ill_n   = dec_ill_c;
                        state_n     = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (acc_c && pop_c) begin
                        out_instr_n = dec_instr_c;
                        out_op_n    = Operand;
                        out_ill_n   = dec_ill_c;
                    end else if (acc_c) begin
                        skid_instr_n = dec_instr_c;
                        skid_op_n    = Operand;
                        skid_ill_n   = dec_ill_c;
                        state_n      = OCC_TWO;
                    end else if (pop_c) begin
                        state_n = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop_c) begin
                        out_instr_n = skid_instr_q;
                        out_op_n    = skid_op_q;
                        out_ill_n   = skid_ill_q;
                        state_n     = OCC_ONE;
                    end
                end
                default: state_n = OCC_EMPTY;
            endcase

            if (acc_c && dec_ill_c && (cnt_q != CNT_MAX)) begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end

        out_valid_n = (state_n != OCC_EMPTY);
        in_ready_n  = (state_n != OCC_TWO);
    end

    // State, storage and flag registers; reset drops every entry immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= OCC_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_op_q     <= '0;
            out_ill_q    <= 1'b0;
            skid_instr_q <= '0;
            skid_op_q    <= '0;
            skid_ill_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state        <= state_n;
            in_ready_q   <= in_ready_n;
            out_valid_q  <= out_valid_n;
            out_instr_q  <= out_instr_n;
            out_op_q     <= out_op_n;
            out_ill_q    <= out_ill_n;
            skid_instr_q <= skid_instr_n;
            skid_op_q    <= skid_op_n;
            skid_ill_q   <= skid_ill_n;
            cnt_q        <= cnt_n;
        end
    end

    assign InReady      = in_ready_q;
    assign OutValid     = out_valid_q;
    assign Instruction  = out_instr_q;
    assign OutOperand   = out_op_q;
    assign Illegal      = out_ill_q;
    assign IllegalCount = cnt_q;

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
// Bench: a 4-instruction and a 3-instruction decoder driven in lockstep, checked against a queue model.
module tb_instruction_decoder_pipe;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       in_valid;
    logic [1:0] code;
    logic [7:0] operand;
    logic       flush;
    logic       out_ready;

    logic       ir4, ov4, ill4;
    logic [3:0] instr4;
    logic [7:0] op4, cnt4;
    logic       ir3, ov3, ill3;
    logic [2:0] instr3;
    logic [7:0] op3, cnt3;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    instruction_decoder_pipe dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(in_valid), .InReady(ir4),
        .InstructionCode(code), .Operand(operand), .Flush(flush),
        .OutValid(ov4), .OutReady(out_ready), .Instruction(instr4),
        .OutOperand(op4), .Illegal(ill4), .IllegalCount(cnt4)
    );

    instruction_decoder_pipe #(.NUM_INSTR(3)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(in_valid), .InReady(ir3),
        .InstructionCode(code), .Operand(operand), .Flush(flush),
        .OutValid(ov3), .OutReady(out_ready), .Instruction(instr3),
        .OutOperand(op3), .Illegal(ill3), .IllegalCount(cnt3)
    );

    // Reference model: a FIFO of at most two decoded entries plus two saturating counters.
    typedef struct {
        logic [3:0] i4;
        logic       l4;
        logic [2:0] i3;
        logic       l3;
        logic [7:0] op;
    } ent_t;

    ent_t mq[$];
    int   mcnt4 = 0;
    int   mcnt3 = 0;

    function automatic ent_t mk(input logic [1:0] c, input logic [7:0] o);
        ent_t e;
        int   ci = int'(c);
        e.i4 = (ci < 4) ? 4'(1 << ci) : 4'b0;
        e.l4 = (ci >= 4);
        e.i3 = (ci < 3) ? 3'(1 << ci) : 3'b0;
        e.l3 = (ci >= 3);
        e.op = o;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the model with the inputs present before the edge, then step past the edge.
    task automatic tick();
        bit   acc, pop;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        pop = (mq.size() > 0) && out_ready;
        e   = mk(code, operand);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                if (e.l4 && mcnt4 < 255) mcnt4++;
                if (e.l3 && mcnt3 < 255) mcnt3++;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string t);
        bit v;
        v = (mq.size() > 0);
        chk({t, ".ov4"},  32'(ov4),  32'(v));
        chk({t, ".ov3"},  32'(ov3),  32'(v));
        chk({t, ".ir4"},  32'(ir4),  32'(mq.size() < 2));
        chk({t, ".ir3"},  32'(ir3),  32'(mq.size() < 2));
        chk({t, ".cnt4"}, 32'(cnt4), 32'(mcnt4));
        chk({t, ".cnt3"}, 32'(cnt3), 32'(mcnt3));
        if (v) begin
            chk({t, ".instr4"}, 32'(instr4), 32'(mq[0].i4));
            chk({t, ".ill4"},   32'(ill4),   32'(mq[0].l4));
            chk({t, ".op4"},    32'(op4),    32'(mq[0].op));
            chk({t, ".instr3"}, 32'(instr3), 32'(mq[0].i3));
            chk({t, ".ill3"},   32'(ill3),   32'(mq[0].l3));
            chk({t, ".op3"},    32'(op3),    32'(mq[0].op));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx, tx, cyc;

        // Reset values
        Reset_n = 1'b0; in_valid = 1'b0; code = 2'd0; operand = 8'd0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst.ov4",    32'(ov4),    32'd0);
        chk("rst.instr4", 32'(instr4), 32'd0);
        chk("rst.op4",    32'(op4),    32'd0);
        chk("rst.ill3",   32'(ill3),   32'd0);
        chk("rst.cnt3",   32'(cnt3),   32'd0);
        Reset_n = 1'b1;
        tick();
        check_all("post_rst");
        chk("post_rst.ir4", 32'(ir4), 32'd1);

        // Single JUMP with 1-cycle latency
        in_valid = 1'b1; code = 2'd1; operand = 8'h5A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_all("t1");
        chk("t1.instr4", 32'(instr4), 32'b0010);
        chk("t1.op4",    32'(op4),    32'h5A);
        chk("t1.ill4",   32'(ill4),   32'd0);
        tick();
        check_all("t1.drain");

        // Fill both slots with the output stalled, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; code = 2'd0; operand = 8'h11;
        tick(); check_all("t2.push0");
        code = 2'd3; operand = 8'h22;
        tick(); check_all("t2.push1");
        in_valid = 1'b0;
        chk("t2.full_ir4", 32'(ir4),  32'd0);
        chk("t2.cnt3",     32'(cnt3), 32'd1);
        chk("t2.head4",    32'(instr4), 32'b0001);
        chk("t2.headop",   32'(op4),    32'h11);
        out_ready = 1'b1;
        tick(); check_all("t2.pop0");
        chk("t2.second4",  32'(instr4), 32'b1000);
        chk("t2.secondop", 32'(op4),    32'h22);
        chk("t2.second3",  32'(instr3), 32'b000);
        chk("t2.ill3",     32'(ill3),   32'd1);
        chk("t2.ir4",      32'(ir4),    32'd1);
        tick(); check_all("t2.pop1");
        chk("t2.empty", 32'(ov4), 32'd0);

        // Flush from the full state with an illegal input in the same cycle
        out_ready = 1'b0; in_valid = 1'b1;
        code = 2'd0; operand = 8'h33; tick(); check_all("t4.push0");
        code = 2'd1; operand = 8'h44; tick(); check_all("t4.push1");
        flush = 1'b1; code = 2'd3; operand = 8'h55; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_all("t4.flush");
        chk("t4.ov4",  32'(ov4),  32'd0);
        chk("t4.ir4",  32'(ir4),  32'd1);
        chk("t4.cnt3", 32'(cnt3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("t4.after");
        end

        // Counter saturation with 300 back-to-back illegal codes
        in_valid = 1'b1; code = 2'd3; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            operand = 8'(i);
            tick(); check_all("t3.sat");
        end
        in_valid = 1'b0;
        chk("t3.cnt3", 32'(cnt3), 32'd255);
        chk("t3.cnt4", 32'(cnt4), 32'd0);
        tick(); check_all("t3.drain");

        // Random-backpressure stream checked against its own input order
        rx = 0; tx = 0; cyc = 0;
        while (rx < 1000 && cyc < 6000) begin
            in_valid  = (tx < 1000) && ($urandom_range(0, 3) != 0);
            code      = 2'(tx);
            operand   = 8'(tx);
            out_ready = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && out_ready) begin
                chk("sb.op",    32'(op4),    32'(rx & 255));
                chk("sb.instr", 32'(instr4), 32'(1 << (rx % 4)));
                rx++;
            end
            if (in_valid && mq.size() < 2) tx++;
            tick(); check_all("stream");
            cyc++;
        end
        chk("stream.delivered", 32'(rx), 32'd1000);
        in_valid = 1'b0;

        // Asynchronous reset between edges with an illegal entry pending
        out_ready = 1'b0; in_valid = 1'b1; code = 2'd3; operand = 8'h77;
        tick();
        in_valid = 1'b0;
        check_all("t6.pre");
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6.ov4",  32'(ov4),  32'd0);
        chk("t6.ov3",  32'(ov3),  32'd0);
        chk("t6.ill3", 32'(ill3), 32'd0);
        chk("t6.cnt3", 32'(cnt3), 32'd0);
        mq.delete(); mcnt4 = 0; mcnt3 = 0;
        Reset_n = 1'b1;
        tick(); check_all("t6.post");
        chk("t6.ir4", 32'(ir4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_decoder_pipe.md
Name: instruction_decoder_pipe

Overview:
- Parametrised, registered successor to the 2-bit combinational instruction decoder in the CU.
- Decodes a CODE_W-bit instruction code into a NUM_INSTR-wide one-hot Instruction vector, carrying an operand alongside.
- Sits between fetch and execute, with a valid/ready handshake, a 2-entry skid buffer, a flush path for taken jumps, and illegal-code detection and counting.

Parameters:
- CODE_W, 2, width of InstructionCode.
- NUM_INSTR, 4, number of legal instructions (1..2^CODE_W); codes >= NUM_INSTR are illegal.
- OPERAND_W, 8, width of the operand carried with each instruction.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- InValid  input  1  upstream has a code/operand this cycle.
- InReady  output  1  block can accept; transfer occurs when InValid&&InReady.
- InstructionCode  input  CODE_W  encoded instruction.
- Operand  input  OPERAND_W  operand paired with code.
- Flush  input  1  kill all held entries (taken jump).
- OutValid  output  1  decoded entry present at output.
- OutReady  input  1  downstream accepts; transfer when OutValid&&OutReady.
- Instruction  output  NUM_INSTR  one-hot decode; bit i set iff code==i.
- OutOperand  output  OPERAND_W  operand of the output entry.
- Illegal  output  1  output entry carries an illegal code (Instruction all zeros).
- IllegalCount  output  CNT_W  saturating count of accepted illegal codes.

Behaviour:
- Reset (async assert, sync-to-Clk deassert handled upstream):
  - OutValid=0, Instruction=0, OutOperand=0, Illegal=0, IllegalCount=0.
  - Skid entry empty; InReady=1 from the first cycle after reset.
- Decode is performed on input, before registering: Instruction[i] = (InstructionCode==i) for i<NUM_INSTR.
  - Code >= NUM_INSTR: Instruction=0 and Illegal=1.
  - Exactly one of {one Instruction bit, Illegal} is set for every valid entry.
- Latency: 1 cycle. An accepted input appears at the output on the next edge if the output register is free.
- Storage is an output register plus one skid register. The occupancy FSM (decoded from valid bits):
  - EMPTY: output and skid both empty.
  - ONE: output full, skid empty.
  - TWO: both full.
- InReady = !skid_valid, driven directly from a flop (no combinational path from OutReady).
- FSM transitions (no Flush); acc = InValid&&InReady, pop = OutValid&&OutReady:
  - EMPTY: acc -> ONE.
  - ONE: acc&&!pop -> TWO (input held in skid); acc&&pop -> ONE (output reloaded from input); !acc&&pop -> EMPTY.
  - TWO: acc is impossible (InReady=0). pop -> ONE, with the skid moving to output in the same edge.
- Ordering: strict FIFO order. The skid contents always leave before any newer input.
- Flush (highest priority):
  - On the edge where Flush=1, both entries are invalidated and the state becomes EMPTY.
  - An input presented in the same cycle is discarded, even if acc=1, and is not counted.
  - A pop in the same cycle still counts as delivered downstream.
  - OutOperand and Instruction may hold stale data while OutValid=0.
- IllegalCount:
  - Increments by 1 on each acc whose code is illegal, unless Flush is asserted that cycle.
  - Saturates at 2^CNT_W-1. Cleared only by reset.
- Output stability: while OutValid=1 and OutReady=0, Instruction, OutOperand and Illegal hold constant.
- Reset mid-operation: all entries are dropped immediately and asynchronously. There is no partial-transfer recovery.
- Elaboration: NUM_INSTR > 2^CODE_W or NUM_INSTR < 1 is an elaboration error.

Decomposition:
- Shared CU package holds:
  - FSM occupancy encoding (EMPTY/ONE/TWO).
  - Default CODE_W/NUM_INSTR/OPERAND_W.
  - The instruction index constants: ADD=0, JUMP=1, plus two more indices reserved for future instructions.
- One natural sub-module: onehot_decoder (parametrised CODE_W -> NUM_INSTR combinational decode plus illegal flag). It replaces the per-bit gate instances and is reused by other CU decoders.

Test Plan:
- Reset then InValid=1, code=1, Operand=0x5A, OutReady=1 -> next cycle OutValid=1, Instruction=4'b0010, OutOperand=0x5A, Illegal=0.
- OutReady=0; push codes 0, 3 (Operand 0x11, 0x22) -> state TWO, InReady=0. Raise OutReady -> Instruction 4'b0001/0x11, then 4'b1000/0x22 on consecutive cycles; InReady=1 one cycle after the first pop.
- NUM_INSTR=3, push code 3 -> Instruction=3'b000, Illegal=1, IllegalCount=1. Push 300 illegal codes with CNT_W=8 -> IllegalCount=255.
- State TWO, Flush=1 together with InValid=1 (illegal code) -> next cycle OutValid=0, InReady=1, IllegalCount unchanged; the flushed entries never appear.
- Continuous stream codes 0,1,2,3,... with OutReady toggling pseudo-randomly -> output sequence identical to input order, no loss or duplication; scoreboard match over 1000 items.
- Assert Reset_n=0 mid-stream between clock edges -> OutValid, Illegal and IllegalCount go 0 immediately without waiting for Clk; InReady=1 after release.
